// File: rtl/leftshift_iter.sv
// Iterative logical left shifter: one power-of-two stage per cycle (MSB stage first) into a registered accumulator.
// Optional signed-overflow flag enabled by defining LSHIFT_OVF_EN.
module leftshift_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result,
`ifdef LSHIFT_OVF_EN
  output logic               ovf,
`endif
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready=1
  // SHIFT | applying stage cnt_q (SHAMT_W-1 down to 0), one per cycle
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SHAMT_W - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   stage_shifted;
  int unsigned        stage_amt;

  always_comb begin
    stage_amt     = 32'd1 << cnt_q;
    stage_shifted = acc_q << stage_amt;
  end

`ifdef LSHIFT_OVF_EN
  logic ovf_q, ovf_d;
  logic stage_ovf;

  // Shifting back arithmetically recovers the input only if the dropped bits and new MSB all match the old MSB.
  always_comb begin
    stage_ovf = (($signed(stage_shifted) >>> stage_amt) != $signed(acc_q));
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
`ifdef LSHIFT_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = data_operand;
          shamt_d = shamt;
          cnt_d   = CNT_TOP;
          state_d = SHIFT;
`ifdef LSHIFT_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (shamt_q[cnt_q]) begin
          acc_d = stage_shifted;
`ifdef LSHIFT_OVF_EN
          ovf_d = ovf_q | stage_ovf;
`endif
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      shamt_q <= '0;
      cnt_q   <= CNT_TOP;
`ifdef LSHIFT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
`ifdef LSHIFT_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == SHIFT) || (state_q == DONE);
  assign data_result = acc_q;
`ifdef LSHIFT_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_leftshift_iter.sv
// Directed bench for leftshift_iter: vector table plus multi-cycle handshake/reset sequences.
// Build with LSHIFT_OVF_EN defined to also check the overflow flag.
`timescale 1ns/1ps
module tb_leftshift_iter;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operand;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               busy;
`ifdef LSHIFT_OVF_EN
  logic               ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  leftshift_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_operand (data_operand),
    .shamt        (shamt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_result  (data_result),
`ifdef LSHIFT_OVF_EN
    .ovf          (ovf),
`endif
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0]   op;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   res;
    logic               ov;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
`ifdef LSHIFT_OVF_EN
    check(name, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  // Issue one op from IDLE and verify exact latency; leaves the unit in DONE.
  task automatic issue(input logic [WIDTH-1:0] op, input logic [SHAMT_W-1:0] sh, input string tag);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    data_operand = op;
    shamt        = sh;
    in_valid     = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= SHAMT_W; i++) begin
      @(posedge clock);
      #1;
      if (i == SHAMT_W - 1) check({tag, " early out_valid"}, {31'd0, out_valid}, 32'd0);
      if (i == SHAMT_W - 1) check({tag, " busy in shift"}, {31'd0, busy}, 32'd1);
    end
    check({tag, " out_valid latency"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    time t_acc [3];
    logic [WIDTH-1:0] b2b_op  [3];
    logic [WIDTH-1:0] b2b_res [3];
    int guard;

    vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 5'd16, 32'h5678_0000, 1'b1};
    vecs[2] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1};
    vecs[4] = '{32'h0000_0003, 5'd30, 32'hC000_0000, 1'b1};
    vecs[5] = '{32'h0000_1234, 5'd5,  32'h0002_4680, 1'b0};
    vecs[6] = '{32'hFFFF_FF80, 5'd24, 32'h8000_0000, 1'b0};
    vecs[7] = '{32'h4000_0000, 5'd1,  32'h8000_0000, 1'b1};
    vecs[8] = '{32'h0F0F_0F0F, 5'd21, 32'hE1E0_0000, 1'b1};
    vecs[9] = '{32'h5555_5555, 5'd10, 32'h5555_5400, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_operand = '0; shamt = '0;
    #12;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset data_result", data_result, 32'd0);
    check_ovf("reset ovf", 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].sh, $sformatf("vec%0d", i));
      check($sformatf("vec%0d result", i), data_result, vecs[i].res);
      check_ovf($sformatf("vec%0d ovf", i), vecs[i].ov);
      retire($sformatf("vec%0d", i));
    end

    // Stall in DONE with in_valid pulses that must be ignored.
    issue(32'hFFFF_FFFF, 5'd4, "stall");
    check("stall result", data_result, 32'hFFFF_FFF0);
    check_ovf("stall ovf", 1'b0);
    for (int c = 0; c < 3; c++) begin
      data_operand = 32'h0000_0055;
      shamt        = 5'd3;
      in_valid     = (c != 1);
      @(posedge clock);
      #1;
      check("stall held result", data_result, 32'hFFFF_FFF0);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    retire("stall");

    // Reset during the third SHIFT cycle.
    @(negedge clock);
    data_operand = 32'hCAFE_F00D; shamt = 5'd7; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset data_result", data_result, 32'd0);
    check("midreset in_ready", {31'd0, in_ready}, 32'd1);
    #1 reset = 1'b0;
    issue(32'h0000_00FF, 5'd8, "postreset");
    check("postreset result", data_result, 32'h0000_FF00);
    check_ovf("postreset ovf", 1'b0);
    retire("postreset");

    // Back-to-back with out_ready tied high: accepts spaced SHAMT_W+2 clocks.
    b2b_op[0] = 32'h0000_000F; b2b_res[0] = 32'h0000_0F00;
    b2b_op[1] = 32'h0000_0101; b2b_res[1] = 32'h0000_0808;
    b2b_op[2] = 32'h0000_0001; b2b_res[2] = 32'h0000_0002;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      data_operand = b2b_op[j];
      shamt        = (j == 0) ? 5'd8 : ((j == 1) ? 5'd3 : 5'd1);
      in_valid     = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clock);
        guard++;
      end
      check($sformatf("b2b%0d accept", j), {31'd0, in_ready}, 32'd1);
      t_acc[j] = $time;
      guard = 0;
      @(negedge clock);
      while (!out_valid && guard < 20) begin
        @(negedge clock);
        guard++;
      end
      check($sformatf("b2b%0d out_valid", j), {31'd0, out_valid}, 32'd1);
      check($sformatf("b2b%0d result", j), data_result, b2b_res[j]);
    end
    in_valid  = 1'b0;
    check("b2b spacing 0-1", 32'(t_acc[1] - t_acc[0]), 32'd10 * (SHAMT_W + 2));
    check("b2b spacing 1-2", 32'(t_acc[2] - t_acc[1]), 32'd10 * (SHAMT_W + 2));
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("b2b final in_ready", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
